// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch front-end definitions: default geometry and the fetch sequencer state type.
// Geometry defaults follow the existing instruction-side macros when they are already defined.
`ifndef INST_INDEX_SIZE
`define INST_INDEX_SIZE 32
`endif
`ifndef INST_FETCH_NUM
`define INST_FETCH_NUM 4
`endif
`ifndef INST_PACK
`define INST_PACK (32 * `INST_FETCH_NUM)
`endif

package fetch_ctrl_pkg;

    localparam int unsigned INST_INDEX_SIZE = `INST_INDEX_SIZE;
    localparam int unsigned INST_FETCH_NUM  = `INST_FETCH_NUM;
    localparam int unsigned INST_PACK       = `INST_PACK;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_lane_mask.sv
// Maps the word offset of a fetch address inside its packet to the lanes that hold
// instructions at or after that address. Shared with the predecode logic.
module fetch_lane_mask
    import fetch_ctrl_pkg::*;
#(
    parameter  int unsigned FETCH_NUM = INST_FETCH_NUM,
    localparam int unsigned OFF_W     = (FETCH_NUM > 1) ? $clog2(FETCH_NUM) : 1
) (
    input  logic [OFF_W-1:0]     offset,
    output logic [FETCH_NUM-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < FETCH_NUM; i++) begin
            mask[i] = (32'(offset) <= i);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one memory request at a time and registers
// each returned packet with a per-lane valid mask, handling back-pressure and redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned       ADDR_W    = INST_INDEX_SIZE,
    parameter int unsigned       FETCH_NUM = INST_FETCH_NUM,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    buffer_full,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ready,
    input  logic                    mem_valid,
    input  logic [32*FETCH_NUM-1:0] mem_rdata,
    output logic [FETCH_NUM-1:0]    fetch_valid,
    output logic [ADDR_W-1:0]       fetch_pc,
    output logic [32*FETCH_NUM-1:0] fetch_data
);

    localparam int unsigned       OFF_W     = (FETCH_NUM > 1) ? $clog2(FETCH_NUM) : 1;
    localparam int unsigned       PKT_BYTES = FETCH_NUM * 4;
    localparam logic [ADDR_W-1:0] PKT_MASK  = ~ADDR_W'(PKT_BYTES - 1);
    localparam logic [ADDR_W-1:0] PKT_INC   = ADDR_W'(PKT_BYTES);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    fetch_state_t              state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [ADDR_W-1:0]         req_pc_q, req_pc_d;
    logic [FETCH_NUM-1:0]      fv_q, fv_d;
    logic [ADDR_W-1:0]         fpc_q, fpc_d;
    logic [32*FETCH_NUM-1:0]   fdata_q, fdata_d;

    logic                      out_full;
    logic                      out_consume;
    logic                      handshake;
    logic [OFF_W-1:0]          lane_off;
    logic [FETCH_NUM-1:0]      lane_mask;

    assign lane_off = OFF_W'((req_pc_q >> 2) & ADDR_W'(FETCH_NUM - 1));

    fetch_lane_mask #(
        .FETCH_NUM (FETCH_NUM)
    ) u_lane_mask (
        .offset (lane_off),
        .mask   (lane_mask)
    );

    assign out_full    = |fv_q;
    assign out_consume = out_full & ~buffer_full;
    assign handshake   = mem_req & mem_ready;

    assign mem_addr    = pc_q;
    assign fetch_valid = fv_q;
    assign fetch_pc    = fpc_q;
    assign fetch_data  = fdata_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        fv_d     = out_consume ? '0 : fv_q;
        fpc_d    = fpc_q;
        fdata_d  = fdata_q;
        mem_req  = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                mem_req = ~buffer_full & (~out_full | out_consume);
                if (mem_req & mem_ready) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    fdata_d = mem_rdata;
                    fpc_d   = req_pc_q & PKT_MASK;
                    fv_d    = lane_mask;
                    pc_d    = (req_pc_q & PKT_MASK) + PKT_INC;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (mem_valid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above; a response landing in the same cycle is
        // dropped, so nothing is left in flight (this also covers DRAIN, avoiding a hang).
        if (redirect_valid) begin
            pc_d    = redirect_pc & WORD_MASK;
            fv_d    = '0;
            fpc_d   = fpc_q;
            fdata_d = fdata_q;
            case (state_q)
                REQ:     state_d = handshake ? DRAIN : REQ;
                WAIT:    state_d = mem_valid ? REQ : DRAIN;
                DRAIN:   state_d = mem_valid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC & WORD_MASK;
            req_pc_q <= '0;
            fv_q     <= '0;
            fpc_q    <= '0;
            fdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            fv_q     <= fv_d;
            fpc_q    <= fpc_d;
            fdata_q  <= fdata_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (RESET_PC 0 and 0xFFFF_FFF0), a latency-configurable
// memory responder, a transaction-level model checked every cycle, and directed scenarios.
module tb_fetch_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         rst   [2];
    logic         bf    [2];
    logic         rv    [2];
    logic [31:0]  rpc   [2];
    logic         mrdy  [2];
    logic         mval  [2];
    logic [127:0] rdata [2];
    logic         mreq  [2];
    logic [31:0]  maddr [2];
    logic [3:0]   fv    [2];
    logic [31:0]  fpc   [2];
    logic [127:0] fdata [2];
    int unsigned  lat   [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] hs0[$], hs1[$];
    logic [35:0] pk0[$], pk1[$];

    fetch_ctrl #(.ADDR_W(32), .FETCH_NUM(4), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clock(clock), .reset(rst[0]), .buffer_full(bf[0]), .redirect_valid(rv[0]),
        .redirect_pc(rpc[0]), .mem_req(mreq[0]), .mem_addr(maddr[0]), .mem_ready(mrdy[0]),
        .mem_valid(mval[0]), .mem_rdata(rdata[0]), .fetch_valid(fv[0]), .fetch_pc(fpc[0]),
        .fetch_data(fdata[0]));

    fetch_ctrl #(.ADDR_W(32), .FETCH_NUM(4), .RESET_PC(32'hFFFF_FFF0)) u_dut1 (
        .clock(clock), .reset(rst[1]), .buffer_full(bf[1]), .redirect_valid(rv[1]),
        .redirect_pc(rpc[1]), .mem_req(mreq[1]), .mem_addr(maddr[1]), .mem_ready(mrdy[1]),
        .mem_valid(mval[1]), .mem_rdata(rdata[1]), .fetch_valid(fv[1]), .fetch_pc(fpc[1]),
        .fetch_data(fdata[1]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] lane_mask(input logic [31:0] a);
        int unsigned off;
        off = (a >> 2) % 4;
        for (int unsigned i = 0; i < 4; i++) lane_mask[i] = (off <= i);
    endfunction

    function automatic int hs_cnt(input int d);
        return (d != 0) ? hs1.size() : hs0.size();
    endfunction
    function automatic logic [31:0] hs_at(input int d, input int i);
        return (d != 0) ? hs1[i] : hs0[i];
    endfunction
    function automatic int pk_cnt(input int d);
        return (d != 0) ? pk1.size() : pk0.size();
    endfunction
    function automatic logic [35:0] pk_at(input int d, input int i);
        return (d != 0) ? pk1[i] : pk0[i];
    endfunction

    // ---------------- memory responder ----------------
    logic        pend  [2];
    int unsigned cnt   [2];
    logic [31:0] paddr [2];
    int unsigned seq;

    initial begin
        seq = 0;
        for (int d = 0; d < 2; d++) begin
            mval[d] = 1'b0; rdata[d] = '0; pend[d] = 1'b0; cnt[d] = 0; paddr[d] = '0;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (rst[d] && mreq[d] && mrdy[d]) begin
                    pend[d] = 1'b1; cnt[d] = lat[d]; paddr[d] = maddr[d];
                    if (d == 0) hs0.push_back(maddr[d]); else hs1.push_back(maddr[d]);
                end
            end
            @(posedge clock);
            #1;
            for (int d = 0; d < 2; d++) begin
                mval[d] = 1'b0;
                if (!rst[d]) pend[d] = 1'b0;
                else if (pend[d]) begin
                    cnt[d] = cnt[d] - 1;
                    if (cnt[d] == 0) begin
                        pend[d] = 1'b0;
                        mval[d] = 1'b1;
                        seq++;
                        for (int unsigned i = 0; i < 4; i++)
                            rdata[d][32*i +: 32] = 32'hC0DE_0000 ^ (paddr[d] + 4*i) ^ (seq << 20);
                    end
                end
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    logic         m_idle [2];
    logic         m_out  [2];
    logic         m_drop [2];
    logic [31:0]  m_addr [2];
    logic [31:0]  m_pc   [2];
    logic [3:0]   e_fv   [2];
    logic [31:0]  e_fpc  [2];
    logic [127:0] e_fd   [2];
    logic         p_full [2];
    logic         p_bf   [2];

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            logic e_req, newly, resp;
            logic [31:0] base;
            if (!rst[d]) begin
                m_idle[d] = 1'b1; m_out[d] = 1'b0; m_drop[d] = 1'b0; m_addr[d] = '0;
                m_pc[d] = (d != 0) ? 32'hFFFF_FFF0 : 32'h0;
                e_fv[d] = '0; e_fpc[d] = '0; e_fd[d] = '0;
                p_full[d] = 1'b0; p_bf[d] = 1'b0;
            end
            // a request may go out only when nothing is in flight and the buffer has room
            e_req = rst[d] && !m_idle[d] && !m_out[d] && !bf[d];
            chk($sformatf("d%0d.fetch_valid", d), 128'(fv[d]), 128'(e_fv[d]));
            chk($sformatf("d%0d.fetch_pc", d), 128'(fpc[d]), 128'(e_fpc[d]));
            chk($sformatf("d%0d.fetch_data", d), fdata[d], e_fd[d]);
            chk($sformatf("d%0d.mem_req", d), 128'(mreq[d]), 128'(e_req));
            if (e_req) chk($sformatf("d%0d.mem_addr", d), 128'(maddr[d]), 128'(m_pc[d]));

            if (fv[d] != 4'h0 && !(p_full[d] && p_bf[d])) begin
                if (d == 0) pk0.push_back({fv[d], fpc[d]}); else pk1.push_back({fv[d], fpc[d]});
            end
            p_full[d] = (fv[d] != 4'h0);
            p_bf[d]   = bf[d];

            if (rst[d]) begin
                newly = e_req && mrdy[d];
                resp  = mval[d] && m_out[d];
                m_idle[d] = 1'b0;
                if (e_fv[d] != 4'h0 && !bf[d]) e_fv[d] = '0;
                if (rv[d]) begin
                    e_fv[d] = '0;
                    if (resp) m_out[d] = 1'b0;
                    else if (m_out[d]) m_drop[d] = 1'b1;
                    if (newly) begin m_out[d] = 1'b1; m_drop[d] = 1'b1; end
                    m_pc[d] = rpc[d] & ~32'h3;
                end else begin
                    if (resp) begin
                        m_out[d] = 1'b0;
                        if (!m_drop[d]) begin
                            base     = m_addr[d] & ~32'hF;
                            e_fv[d]  = lane_mask(m_addr[d]);
                            e_fpc[d] = base;
                            e_fd[d]  = rdata[d];
                            m_pc[d]  = base + 32'h10;
                        end
                    end
                    if (newly) begin m_out[d] = 1'b1; m_drop[d] = 1'b0; m_addr[d] = m_pc[d]; end
                end
            end
        end
    end

    // ---------------- bounded waits ----------------
    task automatic wait_hs(input int d, input int n);
        int unsigned k = 0;
        while (hs_cnt(d) < n && k < 300) begin @(negedge clock); #1; k++; end
        if (hs_cnt(d) < n) begin
            checks++; failures++;
            $display("FAIL timeout_hs d%0d actual=%0d required=%0d", d, hs_cnt(d), n);
        end
    endtask

    task automatic wait_pk(input int d, input int n);
        int unsigned k = 0;
        while (pk_cnt(d) < n && k < 300) begin @(negedge clock); #1; k++; end
        if (pk_cnt(d) < n) begin
            checks++; failures++;
            $display("FAIL timeout_pkt d%0d actual=%0d required=%0d", d, pk_cnt(d), n);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n, np;
        int unsigned k;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; bf[d] = 1'b0; rv[d] = 1'b0; rpc[d] = '0; mrdy[d] = 1'b1;
        end
        lat[0] = 1; lat[1] = 3;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.fetch_valid", 128'(fv[0]), 128'h0);
        chk("reset.mem_req", 128'(mreq[0]), 128'h0);
        chk("reset.fetch_pc", 128'(fpc[1]), 128'h0);
        rst[0] = 1'b1;

        // linear fetch, latency 1
        wait_hs(0, 3);
        chk("seq.addr0", 128'(hs_at(0, 0)), 128'h0);
        chk("seq.addr1", 128'(hs_at(0, 1)), 128'h10);
        chk("seq.addr2", 128'(hs_at(0, 2)), 128'h20);
        wait_pk(0, 2);
        chk("seq.pkt0", 128'(pk_at(0, 0)), 128'h0_0000_0000 | (128'hF << 32));
        chk("seq.pkt1", 128'(pk_at(0, 1)), 128'h10 | (128'hF << 32));

        // redirect while in REQ (memory not ready)
        n = hs_cnt(0);
        wait_hs(0, n + 1);
        @(posedge clock); #1;
        mrdy[0] = 1'b0;
        np = pk_cnt(0);
        wait_pk(0, np + 1);
        @(posedge clock); #1;
        rv[0] = 1'b1; rpc[0] = 32'h1008;
        @(posedge clock); #1;
        rv[0] = 1'b0; mrdy[0] = 1'b1;
        n = hs_cnt(0); np = pk_cnt(0);
        wait_hs(0, n + 1);
        chk("redir_req.addr", 128'(hs_at(0, n)), 128'h1008);
        wait_pk(0, np + 1);
        chk("redir_req.pkt", 128'(pk_at(0, np)), (128'hC << 32) | 128'h1000);
        wait_hs(0, n + 2);
        chk("redir_req.next", 128'(hs_at(0, n + 1)), 128'h1010);

        // redirect while in WAIT, latency 3
        lat[0] = 3;
        n = hs_cnt(0);
        wait_hs(0, n + 1);
        @(posedge clock); #1;
        rv[0] = 1'b1; rpc[0] = 32'h40;
        @(posedge clock); #1;
        rv[0] = 1'b0;
        np = pk_cnt(0); n = hs_cnt(0);
        wait_hs(0, n + 1);
        chk("redir_wait.addr", 128'(hs_at(0, n)), 128'h40);
        chk("redir_wait.no_pkt", 128'(pk_cnt(0)), 128'(np));

        // redirect coinciding with mem_valid
        n = hs_cnt(0);
        wait_hs(0, n + 1);
        repeat (3) @(posedge clock);
        #1;
        rv[0] = 1'b1; rpc[0] = 32'h200;
        @(posedge clock); #1;
        rv[0] = 1'b0;
        np = pk_cnt(0); n = hs_cnt(0);
        wait_hs(0, n + 1);
        chk("redir_valid.addr", 128'(hs_at(0, n)), 128'h200);
        chk("redir_valid.no_pkt", 128'(pk_cnt(0)), 128'(np));

        // back-pressure with a full output register
        lat[0] = 1;
        k = 0;
        while (mval[0] !== 1'b1 && k < 300) begin @(negedge clock); #1; k++; end
        if (mval[0] !== 1'b1) begin
            checks++; failures++;
            $display("FAIL timeout_mval actual=0 required=1");
        end
        @(posedge clock); #1;
        bf[0] = 1'b1;
        repeat (5) begin
            @(negedge clock); #1;
            chk("bp.fetch_valid", 128'(fv[0]), 128'hF);
            chk("bp.fetch_pc", 128'(fpc[0]), 128'h200);
            chk("bp.mem_req", 128'(mreq[0]), 128'h0);
        end
        @(posedge clock); #1;
        bf[0] = 1'b0;
        @(negedge clock); #1;
        chk("bp.release_req", 128'(mreq[0]), 128'h1);
        chk("bp.release_addr", 128'(maddr[0]), 128'h210);
        @(negedge clock); #1;
        chk("bp.consumed", 128'(fv[0]), 128'h0);

        // RESET_PC wrap and async reset mid-WAIT
        @(posedge clock); #1;
        rst[1] = 1'b1;
        wait_hs(1, 2);
        chk("wrap.addr0", 128'(hs_at(1, 0)), 128'hFFFF_FFF0);
        chk("wrap.addr1", 128'(hs_at(1, 1)), 128'h0);
        chk("wrap.pkt0", 128'(pk_at(1, 0)), (128'hF << 32) | 128'hFFFF_FFF0);
        @(posedge clock); #1;
        chk("wrap.pc_before_reset", 128'(fpc[1]), 128'hFFFF_FFF0);
        #2;
        rst[1] = 1'b0;
        #1;
        chk("areset.fetch_valid", 128'(fv[1]), 128'h0);
        chk("areset.fetch_pc", 128'(fpc[1]), 128'h0);
        chk("areset.fetch_data", fdata[1], 128'h0);
        chk("areset.mem_req", 128'(mreq[1]), 128'h0);
        @(posedge clock); #1;
        rst[1] = 1'b1;
        wait_hs(1, 3);
        chk("areset.restart", 128'(hs_at(1, 2)), 128'hFFFF_FFF0);

        repeat (4) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
